// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - UART receiver: synchronised rx line to an 8-bit valid/ready byte stream with error pulses.
// Optional even-parity checking is enabled by defining UART_BYTE_RX_PARITY_EN.
module uart_byte_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       busy,
  output logic       framing_error,
`ifdef UART_BYTE_RX_PARITY_EN
  output logic       parity_error,
`endif
  output logic       overrun
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              fe_q, fe_d;
  logic              ov_q, ov_d;
  logic              deliver;
`ifdef UART_BYTE_RX_PARITY_EN
  logic              par_bad_q, par_bad_d;
  logic              pe_q, pe_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
`ifdef UART_BYTE_RX_PARITY_EN
      par_bad_q <= 1'b0;
      pe_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
`ifdef UART_BYTE_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      pe_q      <= pe_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    fe_d      = 1'b0;
    ov_d      = 1'b0;
    deliver   = 1'b0;
`ifdef UART_BYTE_RX_PARITY_EN
    par_bad_d = par_bad_q;
    pe_d      = 1'b0;
`endif

    if (valid_q && m_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        bit_d = '0;
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_BYTE_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_BYTE_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          par_bad_d = ^{shift_q, rx_s};
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = S_IDLE;
`ifdef UART_BYTE_RX_PARITY_EN
            deliver = !par_bad_q;
            pe_d    = par_bad_q;
`else
            deliver = 1'b1;
`endif
          end else begin
            fe_d    = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BREAK: begin
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (deliver) begin
      if (!valid_q || m_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  assign m_data        = data_q;
  assign m_valid       = valid_q;
  assign busy          = busy_q;
  assign framing_error = fe_q;
  assign overrun       = ov_q;
`ifdef UART_BYTE_RX_PARITY_EN
  assign parity_error  = pe_q;
`endif

endmodule
